// File: rtl/pal_cfg_if.sv
// Configuration port bundle for pal_macrocell_array: serial load/commit
// control from the host (master) and load status plus chain out from the
// fabric (slave).
interface pal_cfg_if;
   logic cfg_en;    // high = shift; sampled falling level = commit request
   logic cfg_in;    // serial config bit, MSB of the config vector first
   logic cfg_done;  // sticky: last load committed
   logic cfg_err;   // sticky: last load had wrong length and was discarded
   logic cfg_out;   // serial chain out (readback build only, else 0)

   modport master (
      output cfg_en,
      output cfg_in,
      input  cfg_done,
      input  cfg_err,
      input  cfg_out
   );

   modport slave (
      input  cfg_en,
      input  cfg_in,
      output cfg_done,
      output cfg_err,
      output cfg_out
   );
endinterface

// File: rtl/pal_macrocell_array.sv
// pal_macrocell_array: parametrised PAL fabric (AND plane, OR plane and one
// macrocell per output with registered/combinational select, output
// inversion and registered feedback into the AND plane).
// Configuration is shifted into a shadow chain and copied into the active
// config only when exactly CFG_BITS bits were loaded, so the live fabric
// never runs on a partial config.
// Optional feature macro: PAL_READBACK_EN. When defined, cfg_out is the
// shadow chain MSB and the shadow reloads from the active config on the
// edge after a commit, so the next load streams the active config out.
module pal_macrocell_array #(
   parameter int N = 8,   // primary input variables
   parameter int P = 10,  // product terms
   parameter int M = 4    // outputs / macrocells
) (
   input  logic          clk,
   input  logic          res_n,
   pal_cfg_if.slave      cfg,
   input  logic [N-1:0]  in_vars,
   output logic [M-1:0]  out_vals
);

   localparam int L        = 2 * (N + M);            // literals per term
   localparam int CFG_BITS = P * L + M * P + 2 * M;  // config vector length
   localparam int A_BASE   = P * L;                  // OR plane base
   localparam int B_BASE   = A_BASE + M * P;         // macrocell bits base
   localparam int CNT_W    = $clog2(CFG_BITS + 2);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] active_q, active_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [M-1:0]        q_q, q_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                commit_s;

   logic [L-1:0]        lit_s;
   logic [P-1:0]        term_s;
   logic [M-1:0]        sum_s;

   // Literal order: in_vars, ~in_vars, q, ~q. Feedback is taken from the
   // macrocell registers only, which keeps the fabric free of loops.
   assign lit_s = {~q_q, q_q, ~in_vars, in_vars};

   genvar gp, gm;
   generate
      for (gp = 0; gp < P; gp++) begin : g_term
         // A term with no literal selected is forced to 0.
         assign term_s[gp] = (|active_q[gp*L +: L]) &
                             (&(lit_s | ~active_q[gp*L +: L]));
      end
      for (gm = 0; gm < M; gm++) begin : g_cell
         assign sum_s[gm]    = |(active_q[A_BASE + gm*P +: P] & term_s);
         assign out_vals[gm] = (active_q[B_BASE + 2*gm] ? q_q[gm] : sum_s[gm])
                               ^ active_q[B_BASE + 2*gm + 1];
      end
   endgenerate

`ifdef PAL_READBACK_EN
   logic reload_q, reload_d;
   assign cfg.cfg_out = shadow_q[CFG_BITS-1];
`else
   assign cfg.cfg_out = 1'b0;
`endif

   assign cfg.cfg_done = done_q;
   assign cfg.cfg_err  = err_q;

   // Load FSM next state: shifting, length check, atomic commit.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      err_d    = err_q;
      commit_s = 1'b0;
`ifdef PAL_READBACK_EN
      reload_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cfg.cfg_en) begin
               shadow_d = {shadow_q[CFG_BITS-2:0], cfg.cfg_in};
               cnt_d    = CNT_W'(1);
               done_d   = 1'b0;
               err_d    = 1'b0;
               state_d  = ST_SHIFT;
            end else begin
`ifdef PAL_READBACK_EN
               if (reload_q) begin
                  shadow_d = active_q;
               end else begin
                  shadow_d = shadow_q;
               end
`else
               shadow_d = shadow_q;
`endif
            end
         end
         ST_SHIFT: begin
            if (cfg.cfg_en) begin
               shadow_d = {shadow_q[CFG_BITS-2:0], cfg.cfg_in};
               if (cnt_q != CNT_SAT) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = cnt_q;
               end
            end else begin
               if (cnt_q == CNT_FULL) begin
                  active_d = shadow_q;
                  done_d   = 1'b1;
                  commit_s = 1'b1;
`ifdef PAL_READBACK_EN
                  reload_d = 1'b1;
`endif
               end else begin
                  err_d = 1'b1;
               end
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Macrocell registers capture the sum, except on the commit edge.
   always_comb begin
      if (commit_s) begin
         q_d = {M{1'b0}};
      end else begin
         q_d = sum_s;
      end
   end

   // State, config and macrocell registers.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q  <= ST_IDLE;
         shadow_q <= {CFG_BITS{1'b0}};
         active_q <= {CFG_BITS{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         q_q      <= {M{1'b0}};
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         q_q      <= q_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

`ifdef PAL_READBACK_EN
   // One-cycle marker after a commit that triggers the shadow reload.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         reload_q <= 1'b0;
      end else begin
         reload_q <= reload_d;
      end
   end
`endif

endmodule

// File: tb/tb_pal_macrocell_array.sv
// Self-checking bench for pal_macrocell_array with a behavioural model that
// evaluates the config vector literally and tracks a load as a bit queue.
module tb_pal_macrocell_array;

   localparam int N  = 8;
   localparam int P  = 10;
   localparam int M  = 4;
   localparam int L  = 2 * (N + M);
   localparam int CB = P * L + M * P + 2 * M;
   localparam int AB = P * L;
   localparam int BB = AB + M * P;

   logic          clk = 1'b0;
   logic          res_n;
   logic [N-1:0]  in_vars;
   logic [M-1:0]  out_vals;

   pal_cfg_if cfg ();

   pal_macrocell_array #(.N(N), .P(P), .M(M)) dut (
      .clk      (clk),
      .res_n    (res_n),
      .cfg      (cfg),
      .in_vars  (in_vars),
      .out_vals (out_vals)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [CB-1:0] m_active;
   logic [M-1:0]  m_q;
   logic          m_done, m_err, m_loading;
   bit            bits_q[$];

   function automatic logic [M-1:0] f_sum(input logic [CB-1:0] c,
                                          input logic [N-1:0] iv,
                                          input logic [M-1:0] qv);
      logic [P-1:0] t;
      logic [M-1:0] s;
      logic lit;
      bit any, all;
      for (int p = 0; p < P; p++) begin
         any = 0;
         all = 1;
         for (int l = 0; l < L; l++) begin
            if (c[p*L + l]) begin
               any = 1;
               if (l < N)              lit = iv[l];
               else if (l < 2*N)       lit = ~iv[l-N];
               else if (l < 2*N + M)   lit = qv[l-2*N];
               else                    lit = ~qv[l-2*N-M];
               if (!lit) all = 0;
            end
         end
         t[p] = any && all;
      end
      for (int m = 0; m < M; m++) begin
         s[m] = 1'b0;
         for (int p = 0; p < P; p++)
            if (c[AB + m*P + p] && t[p]) s[m] = 1'b1;
      end
      return s;
   endfunction

   function automatic logic [M-1:0] f_out(input logic [CB-1:0] c,
                                          input logic [N-1:0] iv,
                                          input logic [M-1:0] qv);
      logic [M-1:0] s, o;
      s = f_sum(c, iv, qv);
      for (int m = 0; m < M; m++)
         o[m] = (c[BB + 2*m] ? qv[m] : s[m]) ^ c[BB + 2*m + 1];
      return o;
   endfunction

   function automatic logic [CB-1:0] rand_cfg();
      logic [CB-1:0] c;
      for (int k = 0; k < CB; k++)
         c[k] = (k < AB) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      return c;
   endfunction

   task automatic model_reset();
      m_active  = '0;
      m_q       = '0;
      m_done    = 1'b0;
      m_err     = 1'b0;
      m_loading = 1'b0;
      bits_q.delete();
   endtask

   // One clock with the given config inputs; checks before and after the edge.
   task automatic step(input logic en, input logic b, input logic [N-1:0] iv);
      logic [M-1:0]  exp_o;
      logic [CB-1:0] newc;
      bit commit;
      cfg.cfg_en = en;
      cfg.cfg_in = b;
      in_vars    = iv;
      #1;
      exp_o = f_out(m_active, iv, m_q);
      checks++;
      if (out_vals !== exp_o) begin
         errors++;
         $display("FAIL out_pre: got %h expected %h", out_vals, exp_o);
      end
      commit = 0;
      if (en) begin
         if (!m_loading) begin
            bits_q.delete();
            m_done    = 1'b0;
            m_err     = 1'b0;
            m_loading = 1'b1;
         end
         bits_q.push_back(b);
      end else if (m_loading) begin
         m_loading = 1'b0;
         if (bits_q.size() == CB) commit = 1;
         else m_err = 1'b1;
      end
      if (commit) begin
         for (int i = 0; i < CB; i++) newc[CB-1-i] = bits_q[i];
         m_q      = '0;
         m_active = newc;
         m_done   = 1'b1;
      end else begin
         m_q = f_sum(m_active, iv, m_q);
      end
      @(posedge clk);
      #1;
      exp_o = f_out(m_active, iv, m_q);
      checks++;
      if (out_vals !== exp_o) begin
         errors++;
         $display("FAIL out_post: got %h expected %h", out_vals, exp_o);
      end
      checks++;
      if (cfg.cfg_done !== m_done) begin
         errors++;
         $display("FAIL cfg_done: got %b expected %b", cfg.cfg_done, m_done);
      end
      checks++;
      if (cfg.cfg_err !== m_err) begin
         errors++;
         $display("FAIL cfg_err: got %b expected %b", cfg.cfg_err, m_err);
      end
`ifndef PAL_READBACK_EN
      checks++;
      if (cfg.cfg_out !== 1'b0) begin
         errors++;
         $display("FAIL cfg_out_tied: got %b expected 0", cfg.cfg_out);
      end
`endif
   endtask

   // Shift nbits (MSB of c first, random filler past CB), then drop cfg_en.
   task automatic load(input logic [CB-1:0] c, input int nbits,
                       input bit rb_chk, input logic [CB-1:0] rb_exp);
      logic bb;
      for (int i = 0; i < nbits; i++) begin
         bb = (i < CB) ? c[CB-1-i] : 1'($urandom);
`ifdef PAL_READBACK_EN
         if (rb_chk && i < CB) begin
            checks++;
            if (cfg.cfg_out !== rb_exp[CB-1-i]) begin
               errors++;
               $display("FAIL readback bit %0d: got %b expected %b",
                        i, cfg.cfg_out, rb_exp[CB-1-i]);
            end
         end
`endif
         step(1'b1, bb, N'($urandom));
      end
      step(1'b0, 1'b0, N'($urandom));
   endtask

   task automatic test_reset();
      res_n      = 1'b0;
      cfg.cfg_en = 1'b0;
      cfg.cfg_in = 1'b0;
      in_vars    = N'($urandom);
      model_reset();
      #7;
      checks++;
      if (out_vals !== 4'h0) begin
         errors++;
         $display("FAIL reset_out: got %h expected 0", out_vals);
      end
      checks++;
      if (cfg.cfg_done !== 1'b0 || cfg.cfg_err !== 1'b0 || cfg.cfg_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: got %b%b%b expected 000",
                  cfg.cfg_done, cfg.cfg_err, cfg.cfg_out);
      end
      #1;
      res_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, N'($urandom));
         checks++;
         if (out_vals !== 4'h0) begin
            errors++;
            $display("FAIL reset_release_out: got %h expected 0", out_vals);
         end
      end
   endtask

   task automatic test_and_or();
      logic [CB-1:0] c;
      c = '0;
      c[0] = 1'b1;
      c[1] = 1'b1;
      c[AB] = 1'b1;
      load(c, CB, 0, '0);
      checks++;
      if (cfg.cfg_done !== 1'b1) begin
         errors++;
         $display("FAIL and_or_done: got %b expected 1", cfg.cfg_done);
      end
      in_vars = 8'h03;
      #1;
      checks++;
      if (out_vals[0] !== 1'b1) begin
         errors++;
         $display("FAIL and_or_03: got %b expected 1", out_vals[0]);
      end
      in_vars = 8'h01;
      #1;
      checks++;
      if (out_vals[0] !== 1'b0) begin
         errors++;
         $display("FAIL and_or_01: got %b expected 0", out_vals[0]);
      end
   endtask

   task automatic test_polarity();
      logic [CB-1:0] c;
      c = '0;
      c[0] = 1'b1;
      c[1] = 1'b1;
      c[AB] = 1'b1;
      c[BB] = 1'b1;
      c[BB+1] = 1'b1;
      load(c, CB, 0, '0);
      in_vars = 8'h03;
      #1;
      checks++;
      if (out_vals[0] !== 1'b1) begin
         errors++;
         $display("FAIL polarity_commit: got %b expected 1", out_vals[0]);
      end
      step(1'b0, 1'b0, 8'h03);
      checks++;
      if (out_vals[0] !== 1'b0) begin
         errors++;
         $display("FAIL polarity_reg: got %b expected 0", out_vals[0]);
      end
   endtask

   task automatic test_feedback();
      logic [CB-1:0] c;
      c = '0;
      c[2*N + M] = 1'b1;
      c[AB] = 1'b1;
      c[BB] = 1'b1;
      load(c, CB, 0, '0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_vals[0] !== 1'(k % 2)) begin
            errors++;
            $display("FAIL feedback_toggle %0d: got %b expected %0d",
                     k, out_vals[0], k % 2);
         end
         step(1'b0, 1'b0, N'($urandom));
      end
   endtask

   task automatic test_length_err();
      load(rand_cfg(), CB - 1, 0, '0);
      checks++;
      if (cfg.cfg_err !== 1'b1 || cfg.cfg_done !== 1'b0) begin
         errors++;
         $display("FAIL short_load: got err=%b done=%b expected err=1 done=0",
                  cfg.cfg_err, cfg.cfg_done);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, N'($urandom));
      load(rand_cfg(), CB + 1, 0, '0);
      checks++;
      if (cfg.cfg_err !== 1'b1 || cfg.cfg_done !== 1'b0) begin
         errors++;
         $display("FAIL long_load: got err=%b done=%b expected err=1 done=0",
                  cfg.cfg_err, cfg.cfg_done);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, N'($urandom));
      load(rand_cfg(), CB, 0, '0);
      checks++;
      if (cfg.cfg_err !== 1'b0 || cfg.cfg_done !== 1'b1) begin
         errors++;
         $display("FAIL good_load: got err=%b done=%b expected err=0 done=1",
                  cfg.cfg_err, cfg.cfg_done);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [CB-1:0] c;
      c = rand_cfg();
      for (int i = 0; i < 100; i++) step(1'b1, c[CB-1-i], N'($urandom));
      res_n = 1'b0;
      cfg.cfg_en = 1'b0;
      model_reset();
      #2;
      checks++;
      if (out_vals !== 4'h0 || cfg.cfg_done !== 1'b0 || cfg.cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got out=%h done=%b err=%b expected 0 0 0",
                  out_vals, cfg.cfg_done, cfg.cfg_err);
      end
      res_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, N'($urandom));
   endtask

   task automatic test_hitless();
      logic [CB-1:0] ca, cb;
      ca = rand_cfg();
      cb = rand_cfg();
      load(ca, CB, 0, '0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, N'($urandom));
      load(cb, CB, 1, ca);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, N'($urandom));
   endtask

   initial begin
      test_reset();
      test_and_or();
      test_polarity();
      test_feedback();
      test_length_err();
      test_reset_mid_shift();
      test_hitless();
      test_hitless();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
